// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seg_pkg                                                     |
// | Brief  : Seven-segment constants: hex table, segment bit indices.    |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package seg_pkg;

    localparam int c_seg_a  = 0;
    localparam int c_seg_b  = 1;
    localparam int c_seg_c  = 2;
    localparam int c_seg_d  = 3;
    localparam int c_seg_e  = 4;
    localparam int c_seg_f  = 5;
    localparam int c_seg_g  = 6;
    localparam int c_seg_dp = 7;

    localparam logic [7:0] c_seg_off = 8'h00;

    // Active-high gfedcba patterns for 0..F
    localparam logic [6:0] c_hex_seg [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage
`default_nettype wire

// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seg_scan_driver_if                                          |
// | Brief  : Application-side data/load bus for the segment scanner.     |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
interface seg_scan_driver_if #(
    parameter int DIGITS = 6
);
    logic [4*DIGITS-1:0] data_in;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank_in;
    logic                load;

    modport master (output data_in, output dp_in, output blank_in, output load);
    modport slave  (input  data_in, input  dp_in, input  blank_in, input  load);
endinterface
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seg_hex_decode                                              |
// | Brief  : Nibble + dp + blank to active-high {dp,g..a} pattern.       |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module seg_hex_decode
    import seg_pkg::*;
(
    input  wire logic [3:0] i_nibble,
    input  wire logic       i_dp,
    input  wire logic       i_blank,
    output logic      [7:0] o_seg
);

    always_comb begin
        o_seg = c_seg_off;
        if (!i_blank) begin
            o_seg[c_seg_g:c_seg_a] = c_hex_seg[i_nibble];
            o_seg[c_seg_dp]        = i_dp;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seg_scan_driver                                             |
// | Brief  : Multiplexed N-digit seven-segment scanner with dead cycle   |
// |          and frame-synchronous update. Optional LEADING_ZERO_BLANK_EN|
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS      = 6,
    parameter int CLK_DIV     = 50000,
    parameter int SEG_ACT_LOW = 1,
    parameter int SEL_ACT_LOW = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    seg_scan_driver_if.slave bus,
    output logic [7:0]       seg,
    output logic [DIGITS-1:0] sel,
    output logic             frame_start
);

    localparam int c_cnt_w = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int c_idx_w = (DIGITS > 2) ? $clog2(DIGITS) : 1;
    localparam logic [7:0]        c_seg_inv = {8{SEG_ACT_LOW != 0}};
    localparam logic [DIGITS-1:0] c_sel_inv = {DIGITS{SEL_ACT_LOW != 0}};
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);

    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_idx_w-1:0]   r_idx;
    logic [4*DIGITS-1:0]  r_pend_data, r_shad_data;
    logic [DIGITS-1:0]    r_pend_dp, r_shad_dp;
    logic [DIGITS-1:0]    r_pend_blank, r_shad_blank;
    logic                 r_pend_vld;

    logic                 w_tick;
    logic                 w_commit;
    logic [4*DIGITS-1:0]  w_src_data;
    logic [DIGITS-1:0]    w_src_dp;
    logic [DIGITS-1:0]    w_src_blank;
    logic [DIGITS-1:0]    w_lz_mask;
    logic [DIGITS-1:0]    w_onehot;
    logic [7:0]           w_dec;

    assign w_tick   = (r_cnt == c_cnt_last);
    // A load landing on the wrap tick bypasses pending straight into shadow
    assign w_commit = w_tick && (r_idx == c_idx_last) && (r_pend_vld || bus.load);

    assign w_src_data  = bus.load ? bus.data_in  : r_pend_data;
    assign w_src_dp    = bus.load ? bus.dp_in    : r_pend_dp;
    assign w_src_blank = bus.load ? bus.blank_in : r_pend_blank;

`ifdef LEADING_ZERO_BLANK_EN
    logic w_lz_run;
    always_comb begin
        w_lz_mask = '0;
        w_lz_run  = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (w_src_data[4*i +: 4] != 4'h0 || w_src_dp[i]) w_lz_run = 1'b0;
            w_lz_mask[i] = w_lz_run;
        end
    end
`else
    assign w_lz_mask = '0;
`endif

    assign w_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;

    seg_hex_decode u_dec (
        .i_nibble (r_shad_data[{r_idx, 2'b00} +: 4]),
        .i_dp     (r_shad_dp[r_idx]),
        .i_blank  (r_shad_blank[r_idx]),
        .o_seg    (w_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= c_idx_last;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_vld   <= 1'b0;
            r_shad_data  <= '0;
            r_shad_dp    <= '0;
            r_shad_blank <= '0;
        end else begin
            if (bus.load) begin
                r_pend_data  <= bus.data_in;
                r_pend_dp    <= bus.dp_in;
                r_pend_blank <= bus.blank_in;
            end
            if (w_commit) begin
                r_shad_data  <= w_src_data;
                r_shad_dp    <= w_src_dp;
                r_shad_blank <= w_src_blank | w_lz_mask;
                r_pend_vld   <= 1'b0;
            end else if (bus.load) begin
                r_pend_vld   <= 1'b1;
            end
        end
    end

    // Tick cycle becomes the dark gap while sel moves to the next digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= c_seg_off ^ c_seg_inv;
            sel         <= c_sel_inv;
            frame_start <= 1'b0;
        end else if (w_tick) begin
            seg         <= c_seg_off ^ c_seg_inv;
            sel         <= c_sel_inv;
            frame_start <= 1'b0;
        end else begin
            seg         <= w_dec ^ c_seg_inv;
            sel         <= w_onehot ^ c_sel_inv;
            frame_start <= (r_idx == '0) && (r_cnt == '0);
        end
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised multiplexed seven-segment scanner; successor to the combinational single-digit decoder/selector.
- Takes a packed N-digit hex word with per-digit decimal-point and blank masks, and time-multiplexes it onto a shared segment bus plus one-hot digit selects.
- Includes an inter-digit dead cycle (anti-ghosting) and frame-synchronous, tear-free data update.
- Sits between the application datapath and the board's display pins.

Parameters:
DIGITS, 6, number of digits / width of sel
CLK_DIV, 50000, clocks per digit slot (>=2)
SEG_ACT_LOW, 1, 1 = seg pins active-low (common anode)
SEL_ACT_LOW, 1, 1 = sel pins active-low

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_in  in  4*DIGITS  hex nibbles, digit 0 = bits [3:0] (rightmost)
dp_in  in  DIGITS  decimal point per digit, 1 = lit
blank_in  in  DIGITS  1 = digit dark (segments and dp)
load  in  1  single-cycle strobe capturing data_in/dp_in/blank_in
seg  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
sel  out  DIGITS  one-hot digit enable, polarity per SEL_ACT_LOW
frame_start  out  1  one-cycle pulse when digit 0 becomes active

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0:
  - prescaler cnt=0; idx=DIGITS-1.
  - pending and shadow registers = 0; pend_vld=0.
  - seg=all off, sel=all off, frame_start=0.
- Prescaler: cnt counts 0..CLK_DIV-1 and wraps. tick = (cnt==CLK_DIV-1).
- On tick: idx <= (idx==DIGITS-1) ? 0 : idx+1. Registered outputs go all-off for that next cycle (dead cycle).
- On any non-tick cycle: sel = onehot(idx); seg = decode(shadow digit idx), registered with one cycle of latency.
- Each slot therefore shows CLK_DIV-1 lit cycles plus 1 dead cycle. Frame period = DIGITS*CLK_DIV clocks.
- First digit-0 enable appears CLK_DIV+1 cycles after reset release.
- Decode (active-high, gfedcba):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - seg[7] = dp_in bit.
  - blank bit forces all 8 segments off.
  - Output inversion is applied last, per the polarity parameters.
- Load/commit:
  - load=1 captures all three inputs into pending and sets pend_vld.
  - Repeated loads before commit: last one wins.
  - Commit happens on the tick where idx==DIGITS-1 (the wrap to 0): shadow <= pending, pend_vld <= 0.
  - Without pend_vld, shadow holds its value.
  - load in the same cycle as commit: the incoming load data is committed directly to shadow, and pend_vld ends at 0.
  - Displayed data changes only at frame boundaries; there is no tearing.
- frame_start pulses on the first lit cycle of digit 0.
- If rst_n is asserted mid-frame, all state and outputs clear immediately (asynchronous), and scanning restarts as from power-up.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when committing to shadow, an effective-blank mask is computed from the most significant digit downward. Any digit whose nibble is 0 and whose dp is 0 is blanked, until the first non-zero digit or lit dp. Digit 0 is never auto-blanked. The result is ORed with blank_in.
- Undefined: only blank_in blanks digits; no extra logic is synthesised.

Decomposition:
- Package seg_pkg holds:
  - the 16-entry hex-to-segment constant table
  - the SEG_OFF constant
  - the segment bit-index localparams (a..g, dp)
- One sub-module, seg_hex_decode: combinational nibble+dp+blank -> 8-bit active-high pattern.
- seg_scan_driver owns the prescaler, index, pending/shadow registers, and output registers.

Test Plan:
- Reset: rst_n=0 -> seg=8'hFF, sel=6'h3F, frame_start=0. Release with CLK_DIV=4 -> sel=6'h3E at cycle 5, seg=8'hC0 (zero).
- Scan order: load data_in=24'h543210, dp_in=0 -> across one frame sel goes 3E,3D,3B,37,2F,1F. seg shows C0,F9,A4,B0,99,92 for 3 cycles each, with FF/3F dead cycles between.
- Tear-free update: load 24'hFFFFFF while digit 2 is lit -> digits 2..5 still show old data; new data first appears when frame_start pulses.
- Load collision and overwrite: load A then B before the wrap -> B displayed. load C exactly on the commit tick -> C displayed next frame.
- dp/blank: dp_in=6'h04, blank_in=6'h01 -> digit 2 seg bit7=0 (lit); digit 0 seg=FF with sel still asserted.
- With LEADING_ZERO_BLANK_EN: data_in=24'h000105 -> digits 5..3 dark, digits 2..0 show 1,0,5. data_in=0 -> only digit 0 shows 0.
